// File: rtl/hd_transfer_ctrl_pkg.sv
// Shared widths, FSM encoding and the disk/memory bounds check for the HD block-transfer engine.
// Combinational helpers only; no latency, no backpressure.
package hd_transfer_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 15;
    localparam int DISK_SIZE  = 4096;
    localparam int HD_AW      = 12;
    localparam int LEN_W      = 13;
    localparam int REGION     = 2048;
    localparam int SUM_W      = LEN_W + ADDR_WIDTH + 1;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_SAVE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Sums are taken wide enough that base+length can never wrap.
    function automatic logic range_err(input logic [HD_AW-1:0]      hb,
                                       input logic [ADDR_WIDTH-1:0] mb,
                                       input logic [LEN_W-1:0]      len);
        logic [SUM_W-1:0] hd_end;
        logic [SUM_W-1:0] mem_end;
        hd_end  = SUM_W'(hb) + SUM_W'(len);
        mem_end = SUM_W'(mb) + SUM_W'(len);
        return (hd_end > SUM_W'(DISK_SIZE)) || (mem_end > SUM_W'(2**ADDR_WIDTH));
    endfunction

endpackage

// File: rtl/hd_transfer_ctrl_if.sv
// Bundle of control, CPU-disk, HD and memory signals around the transfer engine.
// master = environment (control unit, CPU, memories); slave = the engine.
interface hd_transfer_ctrl_if;
    import hd_transfer_ctrl_pkg::*;

    logic                  start;
    logic                  dir;
    logic [HD_AW-1:0]      hd_base;
    logic [ADDR_WIDTH-1:0] mem_base;
    logic [LEN_W-1:0]      length;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] cpu_hd_addr;
    logic [DATA_WIDTH-1:0] cpu_hd_wdata;
    logic                  cpu_hd_we;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] hd_addr;
    logic [DATA_WIDTH-1:0] hd_wdata;
    logic                  hd_we;
    logic [DATA_WIDTH-1:0] hd_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output start, dir, hd_base, mem_base, length,
        output cpu_hd_addr, cpu_hd_wdata, cpu_hd_we,
        output hd_rdata, mem_rdata,
        input  busy, done, err, cpu_stall,
        input  hd_addr, hd_wdata, hd_we,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  start, dir, hd_base, mem_base, length,
        input  cpu_hd_addr, cpu_hd_wdata, cpu_hd_we,
        input  hd_rdata, mem_rdata,
        output busy, done, err, cpu_stall,
        output hd_addr, hd_wdata, hd_we,
        output mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/hd_transfer_ctrl_hd_port_mux.sv
// Combinational CPU/DMA mux for the single HD port; DMA owns the port whenever sel (cpu_stall) is high.
// Zero latency; a stalled CPU write is simply not forwarded and must be held by the CPU.
module hd_port_mux
    import hd_transfer_ctrl_pkg::*;
(
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_we,
    output logic [DATA_WIDTH-1:0] hd_addr,
    output logic [DATA_WIDTH-1:0] hd_wdata,
    output logic                  hd_we
);

    assign hd_addr  = sel ? dma_addr  : cpu_addr;
    assign hd_wdata = sel ? dma_wdata : cpu_wdata;
    assign hd_we    = sel ? dma_we    : cpu_we;

endmodule

// File: rtl/hd_transfer_ctrl.sv
// Copies a block between disk and memory one word per RD/WR pair: 2N+1 busy cycles incl. DONE.
// start is only sampled in IDLE; while busy the CPU disk port is stalled and DMA drives the HD.
module hd_transfer_ctrl
    import hd_transfer_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    hd_transfer_ctrl_if.slave bus
);

    state_t                state_q,    state_d;
    logic [LEN_W-1:0]      cnt_q,      cnt_d;
    logic [LEN_W-1:0]      len_q,      len_d;
    logic [HD_AW-1:0]      hd_base_q,  hd_base_d;
    logic [ADDR_WIDTH-1:0] mem_base_q, mem_base_d;
    logic                  dir_q,      dir_d;
    logic                  err_q,      err_d;

    logic [DATA_WIDTH-1:0] hd_ptr;
    logic [ADDR_WIDTH-1:0] mem_ptr;
    logic [DATA_WIDTH-1:0] dma_hd_addr;
    logic [DATA_WIDTH-1:0] dma_hd_wdata;
    logic                  dma_hd_we;
    logic                  stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            hd_base_q  <= '0;
            mem_base_q <= '0;
            dir_q      <= DIR_LOAD;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            hd_base_q  <= hd_base_d;
            mem_base_q <= mem_base_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hd_base_d  = hd_base_q;
        mem_base_d = mem_base_q;
        dir_d      = dir_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dir_d      = bus.dir;
                    hd_base_d  = bus.hd_base;
                    mem_base_d = bus.mem_base;
                    len_d      = bus.length;
                    cnt_d      = '0;
                    err_d      = range_err(bus.hd_base, bus.mem_base, bus.length);
                    state_d    = (err_d || bus.length == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: state_d = ST_WR;
            ST_WR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_d == len_q) ? ST_DONE : ST_RD;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Source and destination share the same offset, so one pointer per port serves both phases.
    assign hd_ptr  = DATA_WIDTH'(hd_base_q) + DATA_WIDTH'(cnt_q);
    assign mem_ptr = mem_base_q + ADDR_WIDTH'(cnt_q);

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.err       = (state_q == ST_DONE) && err_q;
        stall         = bus.busy || (bus.start && state_q == ST_IDLE);
        dma_hd_addr   = '0;
        dma_hd_wdata  = '0;
        dma_hd_we     = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (state_q == ST_RD || state_q == ST_WR) begin
            dma_hd_addr  = hd_ptr;
            bus.mem_addr = mem_ptr;
        end
        if (state_q == ST_WR) begin
            if (dir_q == DIR_LOAD) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.hd_rdata;
            end else begin
                dma_hd_we    = 1'b1;
                dma_hd_wdata = bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_stall = stall;

    hd_port_mux u_hd_port_mux (
        .sel       (stall),
        .cpu_addr  (bus.cpu_hd_addr),
        .cpu_wdata (bus.cpu_hd_wdata),
        .cpu_we    (bus.cpu_hd_we),
        .dma_addr  (dma_hd_addr),
        .dma_wdata (dma_hd_wdata),
        .dma_we    (dma_hd_we),
        .hd_addr   (bus.hd_addr),
        .hd_wdata  (bus.hd_wdata),
        .hd_we     (bus.hd_we)
    );

endmodule

// File: tb/tb_hd_transfer_ctrl.sv
// Drives directed and random transfers against HD/memory models and a copy-level reference.
module tb_hd_transfer_ctrl;
    import hd_transfer_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hd_transfer_ctrl_if bus();

    hd_transfer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] hd_mem  [DISK_SIZE];
    logic [31:0] d_mem   [2**ADDR_WIDTH];
    logic [31:0] ref_hd  [DISK_SIZE];
    logic [31:0] ref_mem [2**ADDR_WIDTH];
    logic        init_done = 1'b0;
    int          hd_wr_cnt = 0;
    int          mem_wr_cnt = 0;
    int          total = 0;
    int          bad = 0;

    // Registered-read HD and memory models; contents are randomised on the first clock.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DISK_SIZE; i++) hd_mem[i] <= $urandom;
            for (int i = 0; i < 2**ADDR_WIDTH; i++) d_mem[i] <= $urandom;
            init_done <= 1'b1;
        end else begin
            if (bus.hd_we && bus.hd_addr < DISK_SIZE) begin
                hd_mem[bus.hd_addr[HD_AW-1:0]] <= bus.hd_wdata;
                hd_wr_cnt <= hd_wr_cnt + 1;
            end
            if (bus.mem_we) begin
                d_mem[bus.mem_addr] <= bus.mem_wdata;
                mem_wr_cnt <= mem_wr_cnt + 1;
            end
        end
        bus.hd_rdata  <= hd_mem[bus.hd_addr[HD_AW-1:0]];
        bus.mem_rdata <= d_mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_arrays(input string tag);
        int bh = 0;
        int bm = 0;
        for (int i = 0; i < DISK_SIZE; i++) if (hd_mem[i] !== ref_hd[i]) bh++;
        for (int i = 0; i < 2**ADDR_WIDTH; i++) if (d_mem[i] !== ref_mem[i]) bm++;
        chk({tag, " hd_contents"}, bh, 0);
        chk({tag, " mem_contents"}, bm, 0);
    endtask

    task automatic run_xfer(input string tag, input logic d, input int hb, input int mb,
                            input int len, input bit cpu_req, input bit restart);
        bit   exp_err;
        int   exp_cyc, exp_hw, exp_mw, hw0, mw0;
        int   cyc, dcnt, done_at, stall_bad;
        logic err_seen;
        bit   finished;
        logic [31:0] cpu_val;
        exp_err = (hb + len > DISK_SIZE) || (mb + len > 2**ADDR_WIDTH);
        exp_cyc = (exp_err || len == 0) ? 1 : 2*len + 1;
        exp_hw = 0;
        exp_mw = 0;
        if (!exp_err) begin
            for (int k = 0; k < len; k++) begin
                if (d == DIR_LOAD) begin ref_mem[mb+k] = ref_hd[hb+k]; exp_mw++; end
                else               begin ref_hd[hb+k]  = ref_mem[mb+k]; exp_hw++; end
            end
        end
        cpu_val = $urandom;
        @(negedge clk);
        hw0 = hd_wr_cnt;
        mw0 = mem_wr_cnt;
        bus.start    = 1'b1;
        bus.dir      = d;
        bus.hd_base  = HD_AW'(hb);
        bus.mem_base = ADDR_WIDTH'(mb);
        bus.length   = LEN_W'(len);
        if (cpu_req) begin
            bus.cpu_hd_addr  = 32'd5;
            bus.cpu_hd_wdata = cpu_val;
            bus.cpu_hd_we    = 1'b1;
        end
        #1 chk({tag, " stall_on_start"}, bus.cpu_stall, 1);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dir      = ~d;
        bus.hd_base  = HD_AW'($urandom);
        bus.mem_base = ADDR_WIDTH'($urandom);
        bus.length   = LEN_W'($urandom);
        cyc = 0; dcnt = 0; done_at = 0; err_seen = 1'b0; stall_bad = 0; finished = 1'b0;
        for (int t = 1; t <= 10000; t++) begin
            @(negedge clk);
            if (restart && t == 3) begin
                bus.start   = 1'b1;
                bus.hd_base = HD_AW'(hb + 7);
                bus.dir     = ~d;
                bus.length  = LEN_W'(1);
            end
            if (restart && t == 4) bus.start = 1'b0;
            #1;
            if (bus.busy) cyc++;
            if (bus.done) begin dcnt++; done_at = t; err_seen = bus.err; end
            if (cpu_req && bus.busy && !bus.cpu_stall) stall_bad++;
            if (!bus.busy) begin finished = 1'b1; break; end
        end
        chk({tag, " finished"}, finished, 1);
        chk({tag, " busy_cycles"}, cyc, exp_cyc);
        chk({tag, " done_count"}, dcnt, 1);
        chk({tag, " done_latency"}, done_at, exp_cyc);
        chk({tag, " err"}, err_seen, exp_err);
        chk({tag, " hd_writes"}, hd_wr_cnt - hw0, exp_hw);
        chk({tag, " mem_writes"}, mem_wr_cnt - mw0, exp_mw);
        cmp_arrays(tag);
        if (cpu_req) begin
            chk({tag, " cpu_stalled"}, stall_bad, 0);
            chk({tag, " cpu_idle_passthru"}, bus.hd_we, 1);
            @(posedge clk);
            #1 bus.cpu_hd_we = 1'b0;
            ref_hd[5] = cpu_val;
            @(negedge clk);
            chk({tag, " cpu_write_hd5"}, hd_mem[5], cpu_val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int   dcnt;
        int   mw0;
        logic d;
        int   hb, mb, len;
        bus.start = 1'b0; bus.dir = 1'b0; bus.hd_base = '0; bus.mem_base = '0; bus.length = '0;
        bus.cpu_hd_addr = 32'h123; bus.cpu_hd_wdata = 32'hCAFE; bus.cpu_hd_we = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DISK_SIZE; i++) ref_hd[i] = hd_mem[i];
        for (int i = 0; i < 2**ADDR_WIDTH; i++) ref_mem[i] = d_mem[i];

        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst err", bus.err, 0);
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst hd_we", bus.hd_we, 0);
        chk("rst mem_addr", 32'(bus.mem_addr), 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst cpu_stall", bus.cpu_stall, 0);
        chk("rst hd_addr_passthru", bus.hd_addr, 32'h123);
        chk("rst hd_wdata_passthru", bus.hd_wdata, 32'hCAFE);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst busy", bus.busy, 0);

        run_xfer("load", DIR_LOAD, 100, REGION, 4, 1'b0, 1'b0);
        run_xfer("save", DIR_SAVE, 4000, 4096, 2, 1'b0, 1'b0);
        run_xfer("range_err", DIR_LOAD, 4090, 0, 10, 1'b0, 1'b0);
        run_xfer("mem_range_err", DIR_SAVE, 0, 32760, 9, 1'b0, 1'b0);
        run_xfer("zero_len", DIR_LOAD, 4090, 0, 0, 1'b0, 1'b0);
        run_xfer("exact_end", DIR_SAVE, DISK_SIZE - 3, 2**ADDR_WIDTH - 3, 3, 1'b0, 1'b0);
        run_xfer("arb", DIR_LOAD, 100, REGION + 16, 4, 1'b1, 1'b0);
        run_xfer("restart", DIR_LOAD, 300, 500, 5, 1'b0, 1'b1);

        // Reset lands on the WR of word 2 of 4: words 0..1 copied, 2..3 untouched.
        for (int k = 0; k < 2; k++) ref_mem[3000+k] = ref_hd[200+k];
        @(negedge clk);
        mw0 = mem_wr_cnt;
        bus.start = 1'b1; bus.dir = DIR_LOAD; bus.hd_base = 12'd200; bus.mem_base = 15'd3000; bus.length = 13'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst mem_we", bus.mem_we, 0);
        chk("midrst mem_addr", 32'(bus.mem_addr), 0);
        chk("midrst cpu_stall", bus.cpu_stall, 0);
        dcnt = 0;
        repeat (3) begin @(negedge clk); if (bus.done) dcnt++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (bus.done) dcnt++; end
        chk("midrst no_done", dcnt, 0);
        chk("midrst mem_writes", mem_wr_cnt - mw0, 2);
        cmp_arrays("midrst");

        for (int n = 0; n < 25; n++) begin
            d   = 1'($urandom);
            len = $urandom_range(0, 9);
            hb  = ($urandom % 4 == 0) ? DISK_SIZE - $urandom_range(1, 8) : $urandom_range(0, DISK_SIZE - 1);
            mb  = ($urandom % 4 == 0) ? 2**ADDR_WIDTH - $urandom_range(1, 8) : $urandom_range(0, 2**ADDR_WIDTH - 1);
            run_xfer($sformatf("rnd%0d", n), d, hb, mb, len, 1'b0, n % 5 == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hd_transfer_ctrl.md
Name: hd_transfer_ctrl

Overview:
- Block-transfer controller between the disk (HD) and main data memory.
- Copies a process image between its disk region and a memory region, in either direction.
- Shares the single HD port between this DMA engine and the CPU's direct disk accesses.
- Sits between the control unit (start/done handshake) and the HD and memory ports; the OS uses it for process load and context save.

Parameters:
- DATA_WIDTH, 32, word width of HD and memory.
- ADDR_WIDTH, 15, memory address width (32768 words).
- DISK_SIZE, 4096, number of HD words.
- HD_AW, 12, width of the disk base address field (log2 DISK_SIZE).
- LEN_W, 13, transfer length width (0..4096 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request transfer; sampled only in IDLE.
- dir  in  1  0 = disk->memory (load), 1 = memory->disk (save).
- hd_base  in  HD_AW  first disk word.
- mem_base  in  ADDR_WIDTH  first memory word.
- length  in  LEN_W  words to copy.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle range-error pulse, coincident with done.
- cpu_hd_addr  in  DATA_WIDTH  CPU disk address.
- cpu_hd_wdata  in  DATA_WIDTH  CPU disk write data.
- cpu_hd_we  in  1  CPU disk write request.
- cpu_stall  out  1  CPU must hold its disk request.
- hd_addr  out  DATA_WIDTH  address to HD.
- hd_wdata  out  DATA_WIDTH  data to HD.
- hd_we  out  1  HD write flag.
- hd_rdata  in  DATA_WIDTH  HD registered read data, valid one clk after hd_addr.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one clk after mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; word counter and latched parameters cleared.
  - busy=0, done=0, err=0, hd_we=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - HD port in CPU passthrough.
  - Reset mid-transfer aborts immediately; words already written stay written; no done pulse.
- States:
  - IDLE: on start=1, latch dir, hd_base, mem_base and length; clear counter i.
    - If hd_base+length > DISK_SIZE or mem_base+length > 2**ADDR_WIDTH -> DONE with err.
    - Else if length=0 -> DONE.
    - Else -> RD.
  - RD: drive source address (base+i) on the read port; both write enables 0 -> WR.
  - WR: drive destination address (base+i); write data = source rdata; assert the destination write enable for exactly this cycle; i<=i+1.
    - If i+1 == length -> DONE, else -> RD.
  - DONE: done=1 (and err=1 if the error path was taken) for one cycle -> IDLE.
- Timing:
  - N-word transfer: busy high 2N+1 cycles, starting the cycle after start is accepted, including the DONE cycle.
  - done rises 2N+1 cycles after acceptance; error or zero-length takes 1 cycle.
- Address arithmetic: computed at LEN_W+ADDR_WIDTH+1 bits so the bounds check never wraps. hd_addr is zero-extended to DATA_WIDTH.
- start while busy is ignored; no queueing.
- Arbitration (DMA has priority):
  - cpu_stall = busy | (start & IDLE).
  - While stalled: hd_addr and hd_we come from the DMA, and cpu_hd_we never reaches the HD.
  - When not stalled: hd_addr=cpu_hd_addr, hd_wdata=cpu_hd_wdata, hd_we=cpu_hd_we, all combinational.
- Disk->memory: the HD is never written. Memory->disk: mem_we is never asserted.
- dir, bases and length may change after acceptance without effect.

Decomposition:
- Shared package:
  - State encoding: IDLE, RD, WR, DONE.
  - DIR_LOAD=0, DIR_SAVE=1.
  - DISK_SIZE and region constants (REGION=2048), shared with the OS memory map.
- One sub-module, hd_port_mux: combinational CPU/DMA mux of the HD port, selected by cpu_stall. All sequencing stays in the top.

Test Plan:
- Load (disk->memory): HD[100..103]=A,B,C,D; start with dir=0, hd_base=100, mem_base=2048, length=4 -> mem[2048..2051]=A..D; busy high 9 cycles; done pulses once with err=0; hd_we stays 0.
- Save (memory->disk): mem[4096..4097]=X,Y; start with dir=1, hd_base=4000, mem_base=4096, length=2 -> HD[4000]=X, HD[4001]=Y; mem_we stays 0; done after 5 cycles.
- Range error: hd_base=4090, length=10 -> err=1 with done 1 cycle after start; no hd_we or mem_we pulses. Repeat with length=0 -> done with err=0, no writes.
- Arbitration: while a load runs, CPU drives cpu_hd_we=1 at addr 5 -> cpu_stall=1 and HD[5] unchanged. After done, the same request writes HD[5] in the first idle cycle.
- start asserted again mid-transfer with different hd_base -> ignored; the original transfer completes unchanged.
- Reset mid-transfer: rst_n=0 during WR of word 2 of 4 -> outputs at reset values immediately; words 0..1 written, words 2..3 not; no done pulse; a new start after release works.
